// File: rtl/rbm_ctrl_pkg.sv
// Shared definitions for the RBM vote controller.
//   state_t : controller FSM encoding
//   sat_max : largest signed value representable in 'width' bits
//   sat_min : smallest signed value representable in 'width' bits
//   sext    : sign-extend the low 'width' bits of a value to 64 bits
package rbm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic logic signed [63:0] sext(input logic [63:0] value, input int width);
    logic signed [63:0] shifted;
    shifted = value << (64 - width);
    return shifted >>> (64 - width);
  endfunction

endpackage

// File: rtl/rbm_argmax_margin.sv
// Combinational argmax over packed signed accumulators.
//   acc_in    : OUTPUT_DIM signed accumulators, class g at [g*ACC_WIDTH +: ACC_WIDTH]
//   best_idx  : index of the largest accumulator (ties resolve to the lowest index)
//   best_diff : best minus runner-up, ACC_WIDTH+1 bits, never negative
module rbm_argmax_margin #(
  parameter int OUTPUT_DIM  = 2,
  parameter int ACC_WIDTH   = 16,
  parameter int CLASS_WIDTH = $clog2(OUTPUT_DIM)
) (
  input  logic [OUTPUT_DIM*ACC_WIDTH-1:0] acc_in,
  output logic [CLASS_WIDTH-1:0]          best_idx,
  output logic [ACC_WIDTH:0]              best_diff
);

  logic [OUTPUT_DIM-1:0][ACC_WIDTH-1:0] acc_arr;
  logic signed [ACC_WIDTH-1:0]          best_val;
  logic signed [ACC_WIDTH-1:0]          second_val;
  logic                                 second_seen;

  assign acc_arr = acc_in;

  always_comb begin
    best_val    = $signed(acc_arr[0]);
    best_idx    = '0;
    // Strict '>' keeps the earliest index on ties.
    for (int g = 1; g < OUTPUT_DIM; g++) begin
      if ($signed(acc_arr[g]) > best_val) begin
        best_val = $signed(acc_arr[g]);
        best_idx = CLASS_WIDTH'(g);
      end
    end

    second_val  = best_val;
    second_seen = 1'b0;
    for (int g = 0; g < OUTPUT_DIM; g++) begin
      if ((CLASS_WIDTH'(g) != best_idx) &&
          (!second_seen || ($signed(acc_arr[g]) > second_val))) begin
        second_val  = $signed(acc_arr[g]);
        second_seen = 1'b1;
      end
    end

    // One extra bit holds the full span from min to max without wrapping.
    best_diff = {best_val[ACC_WIDTH-1], best_val} - {second_val[ACC_WIDTH-1], second_val};
  end

endmodule

// File: rtl/rbm_vote_controller.sv
// Iteration controller for stochastic RBM inference.
// Runs the external hidden+classify layer chain repeatedly, accumulating each
// pass's per-class sample with saturation, and reports the argmax class.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : request handshake; iter_num and margin sampled on accept
//   layer_start       : one-cycle pulse restarting the layer chain
//   layer_done        : pass finished, layer_data valid this cycle
//   out_valid/ready   : result handshake
//   out_class/acc/iters/early : argmax, final accumulators, passes run,
//                       and whether the margin ended the run early
module rbm_vote_controller import rbm_ctrl_pkg::*; #(
  parameter int BITLENGTH   = 12,
  parameter int OUTPUT_DIM  = 2,
  parameter int ACC_WIDTH   = 16,
  parameter int ITER_WIDTH  = 16,
  parameter int CLASS_WIDTH = $clog2(OUTPUT_DIM)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ITER_WIDTH-1:0]           iter_num,
  input  logic [ACC_WIDTH-1:0]            margin,
  output logic                            layer_start,
  input  logic                            layer_done,
  input  logic [OUTPUT_DIM*BITLENGTH-1:0] layer_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CLASS_WIDTH-1:0]          out_class,
  output logic [OUTPUT_DIM*ACC_WIDTH-1:0] out_acc,
  output logic [ITER_WIDTH-1:0]           out_iters,
  output logic                            out_early
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(sat_max(ACC_WIDTH));
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(sat_min(ACC_WIDTH));

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SUM_W-1:0] sum);
    if (sum > ACC_MAX)      return ACC_WIDTH'(ACC_MAX);
    else if (sum < ACC_MIN) return ACC_WIDTH'(ACC_MIN);
    else                    return ACC_WIDTH'(sum);
  endfunction

  state_t                                state_q, state_d;
  logic [ITER_WIDTH-1:0]                 iter_num_q, iter_num_d;
  logic [ACC_WIDTH-1:0]                  margin_q, margin_d;
  logic [ITER_WIDTH-1:0]                 count_q, count_d;
  logic [OUTPUT_DIM-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [OUTPUT_DIM-1:0][BITLENGTH-1:0]  sample_q, sample_d;
  logic [CLASS_WIDTH-1:0]                out_class_q, out_class_d;
  logic [OUTPUT_DIM-1:0][ACC_WIDTH-1:0]  out_acc_q, out_acc_d;
  logic [ITER_WIDTH-1:0]                 out_iters_q, out_iters_d;
  logic                                  out_early_q, out_early_d;

  logic [OUTPUT_DIM-1:0][ACC_WIDTH-1:0]  acc_new;
  logic [CLASS_WIDTH-1:0]                arg_idx;
  logic [ACC_WIDTH:0]                    arg_diff;
  logic [ITER_WIDTH-1:0]                 count_inc;
  logic                                  last_pass;
  logic                                  margin_hit;

  for (genvar g = 0; g < OUTPUT_DIM; g++) begin : g_acc
    logic signed [SUM_W-1:0] sum;
    assign sum = SUM_W'(sext(64'(acc_q[g]), ACC_WIDTH)) +
                 SUM_W'(sext(64'(sample_q[g]), BITLENGTH));
    assign acc_new[g] = sat_acc(sum);
  end

  // The early-exit decision looks at the accumulators after this pass's update.
  rbm_argmax_margin #(
    .OUTPUT_DIM (OUTPUT_DIM),
    .ACC_WIDTH  (ACC_WIDTH),
    .CLASS_WIDTH(CLASS_WIDTH)
  ) u_argmax (
    .acc_in   (acc_new),
    .best_idx (arg_idx),
    .best_diff(arg_diff)
  );

  assign count_inc  = count_q + ITER_WIDTH'(1);
  assign last_pass  = (count_inc == iter_num_q);
  assign margin_hit = (margin_q != '0) && (arg_diff >= {1'b0, margin_q});

  always_comb begin
    state_d     = state_q;
    iter_num_d  = iter_num_q;
    margin_d    = margin_q;
    count_d     = count_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    out_class_d = out_class_q;
    out_acc_d   = out_acc_q;
    out_iters_d = out_iters_q;
    out_early_d = out_early_q;
    layer_start = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          iter_num_d = iter_num;
          margin_d   = margin;
          acc_d      = '0;
          count_d    = '0;
          if (iter_num == '0) begin
            out_class_d = '0;
            out_acc_d   = '0;
            out_iters_d = '0;
            out_early_d = 1'b0;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        layer_start = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (layer_done) begin
          sample_d = layer_data;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d   = acc_new;
        count_d = count_inc;
        if (last_pass || margin_hit) begin
          out_class_d = arg_idx;
          out_acc_d   = acc_new;
          out_iters_d = count_inc;
          out_early_d = margin_hit && !last_pass;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      iter_num_q  <= '0;
      margin_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      out_class_q <= '0;
      out_acc_q   <= '0;
      out_iters_q <= '0;
      out_early_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_num_q  <= iter_num_d;
      margin_q    <= margin_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      out_class_q <= out_class_d;
      out_acc_q   <= out_acc_d;
      out_iters_q <= out_iters_d;
      out_early_q <= out_early_d;
    end
  end

  assign out_class = out_class_q;
  assign out_acc   = out_acc_q;
  assign out_iters = out_iters_q;
  assign out_early = out_early_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Testbench for rbm_vote_controller: directed vector table, reset-abort
// sequence, and randomized runs against a behavioural model.
module tb_rbm_vote_controller;

  localparam int BL = 12;
  localparam int OD = 2;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam int CW = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     iter_num;
  logic [AW-1:0]     margin;
  logic              layer_start;
  logic              layer_done;
  logic [OD*BL-1:0]  layer_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_class;
  logic [OD*AW-1:0]  out_acc;
  logic [IW-1:0]     out_iters;
  logic              out_early;

  always #5 clock = ~clock;

  rbm_vote_controller #(
    .BITLENGTH(BL), .OUTPUT_DIM(OD), .ACC_WIDTH(AW), .ITER_WIDTH(IW), .CLASS_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .iter_num(iter_num), .margin(margin), .layer_start(layer_start),
    .layer_done(layer_done), .layer_data(layer_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_acc(out_acc),
    .out_iters(out_iters), .out_early(out_early)
  );

  typedef struct {
    int iter; int mg; int c0; int c1;
    int e_class; int e_acc0; int e_acc1; int e_iters; int e_early; int e_starts;
    int hold;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pd0[64];
  int   pd1[64];
  int   m_class, m_acc0, m_acc1, m_iters, m_early;
  int   r_class, r_acc0, r_acc1, r_iters, r_early, r_starts, r_lat;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int acc_of(input int g);
    logic signed [AW-1:0] t;
    t = out_acc[g*AW +: AW];
    return int'(t);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: add each pass's samples with clamping, stop on count or margin.
  function automatic void model(input int iter, input int mg);
    int a0, a1, d;
    a0 = 0; a1 = 0; m_iters = 0; m_early = 0;
    for (int k = 0; k < iter; k++) begin
      a0 = clamp16(a0 + pd0[k]);
      a1 = clamp16(a1 + pd1[k]);
      m_iters = k + 1;
      d = (a0 >= a1) ? a0 - a1 : a1 - a0;
      if (mg != 0 && d >= mg) begin
        m_early = (m_iters < iter) ? 1 : 0;
        break;
      end
    end
    m_acc0  = a0;
    m_acc1  = a1;
    m_class = (a1 > a0) ? 1 : 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; layer_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Entered and left on a negedge with the DUT idle. Acts as the layer chain:
  // each layer_start is answered with layer_done 1..dmax cycles later.
  task automatic run(input int iter, input int mg, input int dmax, input int hold);
    int cd, pass, cyc, budget;
    r_starts = 0; pass = 0; cd = 0;
    budget = (iter + 2) * (dmax + 4) + 20;
    if (budget > 4000) budget = 4000;
    chk("in_ready_before_request", int'(in_ready), 1);
    in_valid = 1'b1; iter_num = IW'(iter); margin = AW'(mg);
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < budget) begin
      layer_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          layer_done = 1'b1;
          layer_data = {BL'(pd1[pass % 64]), BL'(pd0[pass % 64])};
          pass++;
        end
      end
      if (layer_start) begin
        r_starts++;
        cd = int'($urandom_range(dmax, 1));
      end
      @(negedge clock);
      cyc++;
    end
    layer_done = 1'b0;
    r_lat = cyc;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      do_reset();
      return;
    end
    r_class = int'(out_class); r_acc0 = acc_of(0); r_acc1 = acc_of(1);
    r_iters = int'(out_iters); r_early = int'(out_early);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_out_acc_stable", int'(acc_of(0) == r_acc0 && acc_of(1) == r_acc1), 1);
      chk("hold_out_misc_stable", int'(out_class == CW'(r_class) && out_iters == IW'(r_iters)
                                       && out_early == r_early[0]), 1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("post_handshake_out_valid", int'(out_valid), 0);
    chk("post_handshake_in_ready", int'(in_ready), 1);
    chk("idle_out_iters_hold", int'(out_iters), r_iters);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; iter_num = '0; margin = '0;
    layer_done = 1'b0; layer_data = '0; out_ready = 1'b0;

    //          iter  mg     c0    c1    cls acc0    acc1    it ea st hold
    vecs[0] = '{3,    0,     2,    5,    1,  6,      15,     3, 0, 3, 0};
    vecs[1] = '{100,  10,    4,    0,    0,  12,     0,      3, 1, 3, 1};
    vecs[2] = '{2,    0,     3,    3,    0,  6,      6,      2, 0, 2, 0};
    vecs[3] = '{0,    0,     9,    9,    0,  0,      0,      0, 0, 0, 5};
    vecs[4] = '{20,   0,     2047, -2048,0,  32767,  -32768, 20,0, 20,2};
    vecs[5] = '{1,    0,     -5,   -3,   1,  -5,     -3,     1, 0, 1, 0};
    vecs[6] = '{2,    10,    5,    0,    0,  10,     0,      2, 0, 2, 0};
    vecs[7] = '{5,    1,     0,    1,    1,  0,      1,      1, 1, 1, 0};
    vecs[8] = '{20,   65535, 2047, -2048,0,  32767,  -32768, 17,1, 17,1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_layer_start", int'(layer_start), 0);
    chk("reset_out_class", int'(out_class), 0);
    chk("reset_out_acc", int'(out_acc == '0), 1);
    chk("reset_out_iters", int'(out_iters), 0);
    chk("reset_out_early", int'(out_early), 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 64; k++) begin
        pd0[k] = vecs[i].c0;
        pd1[k] = vecs[i].c1;
      end
      run(vecs[i].iter, vecs[i].mg, 1, vecs[i].hold);
      chk($sformatf("vec%0d_class", i), r_class, vecs[i].e_class);
      chk($sformatf("vec%0d_acc0", i), r_acc0, vecs[i].e_acc0);
      chk($sformatf("vec%0d_acc1", i), r_acc1, vecs[i].e_acc1);
      chk($sformatf("vec%0d_iters", i), r_iters, vecs[i].e_iters);
      chk($sformatf("vec%0d_early", i), r_early, vecs[i].e_early);
      chk($sformatf("vec%0d_starts", i), r_starts, vecs[i].e_starts);
      if (vecs[i].e_iters == 0)
        chk($sformatf("vec%0d_latency_le2", i), int'(r_lat <= 2), 1);
      else
        chk($sformatf("vec%0d_latency", i), r_lat, 3 * vecs[i].e_iters + 1);
    end

    // Reset while waiting on the layer chain; a late layer_done must be ignored.
    in_valid = 1'b1; iter_num = IW'(3); margin = '0;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rstseq_layer_start", int'(layer_start), 1);
    @(negedge clock);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    layer_done = 1'b1;
    layer_data = {BL'(5), BL'(2)};
    @(negedge clock);
    layer_done = 1'b0;
    chk("rstseq_in_ready", int'(in_ready), 1);
    chk("rstseq_out_valid", int'(out_valid), 0);
    chk("rstseq_out_acc", int'(out_acc == '0), 1);
    chk("rstseq_out_iters", int'(out_iters), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("rstseq_quiet", int'(!layer_start && !out_valid && in_ready), 1);
    end

    for (int t = 0; t < 40; t++) begin
      int it, mg, dm, hd;
      it = int'($urandom_range(25, 0));
      mg = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3000, 1)) : 0;
      dm = int'($urandom_range(3, 1));
      hd = int'($urandom_range(2, 0));
      for (int k = 0; k < 64; k++) begin
        pd0[k] = ($urandom_range(3, 0) == 0) ? 2047  : int'($urandom_range(4095, 0)) - 2048;
        pd1[k] = ($urandom_range(3, 0) == 0) ? -2048 : int'($urandom_range(4095, 0)) - 2048;
      end
      model(it, mg);
      run(it, mg, dm, hd);
      chk($sformatf("rnd%0d_class", t), r_class, m_class);
      chk($sformatf("rnd%0d_acc0", t), r_acc0, m_acc0);
      chk($sformatf("rnd%0d_acc1", t), r_acc1, m_acc1);
      chk($sformatf("rnd%0d_iters", t), r_iters, m_iters);
      chk($sformatf("rnd%0d_early", t), r_early, m_early);
      chk($sformatf("rnd%0d_starts", t), r_starts, m_iters);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
